// File: rtl/layer_addr_seq_if.sv
// Pixel request and per-layer record bundle for layer_addr_seq.
// The master side drives pixels and accepts records; the slave side is the sequencer.
interface layer_addr_seq_if #(
    parameter int PIXEL_W = 11,
    parameter int RAM_W   = 26,
    parameter int FLASH_W = 22
);
    logic               pixelValid;
    logic               pixelReady;
    logic [PIXEL_W-1:0] pixelX;
    logic [PIXEL_W-1:0] pixelY;
    logic               outValid;
    logic               outReady;
    logic               outLast;
    logic [7:0]         outLayerIdx;
    logic [7:0]         layerID;
    logic               readRamEn;
    logic               readFlashEn;
    logic [RAM_W-1:0]   ramAddressOffset;
    logic [FLASH_W-1:0] flashAddress;

    modport master (
        output pixelValid, pixelX, pixelY, outReady,
        input  pixelReady, outValid, outLast, outLayerIdx, layerID,
        input  readRamEn, readFlashEn, ramAddressOffset, flashAddress
    );

    modport slave (
        input  pixelValid, pixelX, pixelY, outReady,
        output pixelReady, outValid, outLast, outLayerIdx, layerID,
        output readRamEn, readFlashEn, ramAddressOffset, flashAddress
    );
endinterface

// File: rtl/layer_addr_seq.sv
// Sequential layer address generator: one pixel in, one registered
// hit/address record per layer header out, layer 0 first.
module layer_addr_seq #(
    parameter int NUM_LAYERS = 8,
    parameter int PIXEL_W    = 11,
    parameter int RAM_W      = 26,
    parameter int FLASH_W    = 22,
    parameter int FONT_SHIFT = 12
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic [NUM_LAYERS*128-1:0] headers,
    output logic                      busy,
    layer_addr_seq_if.slave           bus
);
    localparam int         IW       = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam logic [7:0] LAST_IDX = 8'(NUM_LAYERS - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    state_t r_state;
    state_t w_next;

    logic [PIXEL_W-1:0] r_x;
    logic [PIXEL_W-1:0] r_y;
    logic [7:0]         r_idx;
    logic               r_valid;
    logic               r_last;
    logic [7:0]         r_oidx;
    logic [7:0]         r_lid;
    logic               r_ram_en;
    logic               r_flash_en;
    logic [RAM_W-1:0]   r_ram;
    logic [FLASH_W-1:0] r_flash;

    logic [127:0] w_hdrs [NUM_LAYERS];
    logic [127:0] w_hdr;

    for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_hdr
        assign w_hdrs[g] = headers[128*g +: 128];
    end
    assign w_hdr = w_hdrs[r_idx[IW-1:0]];

    logic        w_pop;
    logic        w_spr;
    logic [7:0]  w_id;
    logic [15:0] w_wd;
    logic [15:0] w_ht;
    logic [15:0] w_px;
    logic [15:0] w_py;
    logic [15:0] w_font;
    logic [3:0]  w_g;
    logic [7:0]  w_frame;

    assign w_pop   = w_hdr[0];
    assign w_spr   = w_hdr[1];
    assign w_id    = w_hdr[15:8];
    assign w_wd    = w_hdr[31:16];
    assign w_ht    = w_hdr[47:32];
    assign w_px    = w_hdr[63:48];
    assign w_py    = w_hdr[79:64];
    assign w_font  = w_hdr[95:80];
    assign w_g     = w_hdr[99:96];
    assign w_frame = w_hdr[127:120];

    // Layer-local coordinates, 18-bit signed
    logic signed [17:0] w_lx;
    logic signed [17:0] w_ly;
    assign w_lx = $signed({{(18-PIXEL_W){1'b0}}, r_x}) - $signed({{2{w_px[15]}}, w_px});
    assign w_ly = $signed({{(18-PIXEL_W){1'b0}}, r_y}) - $signed({{2{w_py[15]}}, w_py});

    logic [31:0] w_text_ext;
    logic [16:0] w_ext;
    logic        w_hit;
    assign w_text_ext = {16'd0, w_wd} << w_g;
    assign w_ext = w_spr ? {1'b0, w_wd}
                 : ((|w_text_ext[31:17]) ? '1 : w_text_ext[16:0]);
    assign w_hit = w_pop & ~w_lx[17] & ~w_ly[17]
                 & (w_lx[16:0] < w_ext)
                 & (w_ly[16:0] < {1'b0, w_ht});

    logic [47:0]        w_spr_addr;
    logic [16:0]        w_char;
    logic [16:0]        w_mask;
    logic [47:0]        w_txt_flash;
    logic [RAM_W-1:0]   w_ram;
    logic [FLASH_W-1:0] w_flash;

    assign w_spr_addr  = 48'(w_frame) * 48'(w_wd) * 48'(w_ht)
                       + 48'(w_ly[16:0]) * 48'(w_wd)
                       + 48'(w_lx[16:0]);
    assign w_char      = w_lx[16:0] >> w_g;
    assign w_mask      = (17'd1 << w_g) - 17'd1;
    assign w_txt_flash = (48'(w_font) << FONT_SHIFT)
                       + (48'(w_ly[16:0]) << w_g)
                       + 48'(w_lx[16:0] & w_mask);
    assign w_ram   = !w_hit ? '0 : (w_spr ? w_spr_addr[RAM_W-1:0] : RAM_W'(w_char));
    assign w_flash = (w_hit & ~w_spr) ? w_txt_flash[FLASH_W-1:0] : '0;

    logic w_unused;
    assign w_unused = ^{w_hdr[7:2], w_hdr[119:100],
                        w_spr_addr[47:RAM_W], w_txt_flash[47:FLASH_W]};

    logic w_accept;
    logic w_load;
    logic w_is_last;
    assign w_accept  = (r_state == IDLE) & bus.pixelValid;
    assign w_load    = (r_state == SCAN) & (~r_valid | bus.outReady);
    assign w_is_last = (r_idx == LAST_IDX);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (bus.pixelValid)           w_next = SCAN;
            SCAN:    if (w_load && w_is_last)      w_next = DRAIN;
            DRAIN:   if (r_valid && bus.outReady)  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_x        <= '0;
            r_y        <= '0;
            r_idx      <= '0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_oidx     <= '0;
            r_lid      <= '0;
            r_ram_en   <= 1'b0;
            r_flash_en <= 1'b0;
            r_ram      <= '0;
            r_flash    <= '0;
        end else begin
            if (w_accept) begin
                r_x   <= bus.pixelX;
                r_y   <= bus.pixelY;
                r_idx <= '0;
            end else if (w_load) begin
                r_idx <= r_idx + 8'd1;
            end
            // Record register only moves when empty or being consumed
            if (w_load) begin
                r_valid    <= 1'b1;
                r_last     <= w_is_last;
                r_oidx     <= r_idx;
                r_lid      <= w_id;
                r_ram_en   <= w_hit;
                r_flash_en <= w_hit & ~w_spr;
                r_ram      <= w_ram;
                r_flash    <= w_flash;
            end else if (bus.outReady) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign busy                 = (r_state != IDLE);
    assign bus.pixelReady       = (r_state == IDLE);
    assign bus.outValid         = r_valid;
    assign bus.outLast          = r_last;
    assign bus.outLayerIdx      = r_oidx;
    assign bus.layerID          = r_lid;
    assign bus.readRamEn        = r_ram_en;
    assign bus.readFlashEn      = r_flash_en;
    assign bus.ramAddressOffset = r_ram;
    assign bus.flashAddress     = r_flash;
endmodule

// File: tb/tb_layer_addr_seq.sv
// Bench for layer_addr_seq: directed literal cases plus random headers,
// pixels and backpressure checked against an arithmetic reference model.
module tb_layer_addr_seq;
    localparam int NL = 2;
    localparam int PW = 11;
    localparam int RW = 26;
    localparam int FW = 22;
    localparam int FS = 12;

    logic              clk = 1'b0;
    logic              resetN = 1'b0;
    logic [NL*128-1:0] headers;
    logic              busy;

    layer_addr_seq_if #(.PIXEL_W(PW), .RAM_W(RW), .FLASH_W(FW)) bus();

    layer_addr_seq #(
        .NUM_LAYERS(NL), .PIXEL_W(PW), .RAM_W(RW),
        .FLASH_W(FW), .FONT_SHIFT(FS)
    ) dut (
        .clk(clk), .resetN(resetN), .headers(headers),
        .busy(busy), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int     idx;
        bit     last;
        int     id;
        bit     er;
        bit     ef;
        longint ram;
        longint flash;
    } rec_t;

    rec_t exp_q[$];
    rec_t got_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [127:0] mk_hdr(bit pop, bit spr, int id, int w, int h,
                                             int px, int py, int font, int g, int frame);
        logic [127:0] r;
        r = '0;
        r[0]       = pop;
        r[1]       = spr;
        r[15:8]    = id[7:0];
        r[31:16]   = w[15:0];
        r[47:32]   = h[15:0];
        r[63:48]   = px[15:0];
        r[79:64]   = py[15:0];
        r[95:80]   = font[15:0];
        r[99:96]   = g[3:0];
        r[127:120] = frame[7:0];
        return r;
    endfunction

    function automatic rec_t model(logic [127:0] h, int x, int y, int idx);
        rec_t    r;
        shortint sx, sy;
        longint  lx, ly, w, ht, ex, p2;
        bit      hit;
        sx = h[63:48];
        sy = h[79:64];
        lx = longint'(x) - longint'(sx);
        ly = longint'(y) - longint'(sy);
        w  = longint'(h[31:16]);
        ht = longint'(h[47:32]);
        p2 = longint'(1) << h[99:96];
        ex = h[1] ? w : w * p2;
        if (ex > 131071) ex = 131071;
        hit = h[0] && lx >= 0 && lx < ex && ly >= 0 && ly < ht;
        r.idx = idx;
        r.last = (idx == NL - 1);
        r.id = int'(h[15:8]);
        r.er = 0; r.ef = 0; r.ram = 0; r.flash = 0;
        if (hit && h[1]) begin
            r.er  = 1;
            r.ram = (longint'(h[127:120]) * w * ht + ly * w + lx) % (longint'(1) << RW);
        end else if (hit) begin
            r.er    = 1;
            r.ef    = 1;
            r.ram   = (lx / p2) % (longint'(1) << RW);
            r.flash = (longint'(h[95:80]) * (longint'(1) << FS) + ly * p2 + lx % p2)
                      % (longint'(1) << FW);
        end
        return r;
    endfunction

    always @(negedge clk) begin
        rec_t got;
        if (!resetN) begin
            exp_q.delete();
            n_cmp++;
            if (bus.outValid || busy || !bus.pixelReady || bus.outLast ||
                bus.outLayerIdx != 0 || bus.layerID != 0 || bus.readRamEn ||
                bus.readFlashEn || bus.ramAddressOffset != 0 || bus.flashAddress != 0) begin
                n_bad++;
                $display("FAIL reset_state: valid=%0b busy=%0b ready=%0b ram=%0d flash=%0d required 0 0 1 0 0",
                         bus.outValid, busy, bus.pixelReady, bus.ramAddressOffset, bus.flashAddress);
            end
        end else if (exp_q.size() == 0) begin
            n_cmp++;
            if (bus.outValid || busy || !bus.pixelReady) begin
                n_bad++;
                $display("FAIL idle_state: valid=%0b busy=%0b ready=%0b required 0 0 1",
                         bus.outValid, busy, bus.pixelReady);
            end
            if (bus.pixelValid && bus.pixelReady)
                for (int i = 0; i < NL; i++)
                    exp_q.push_back(model(headers[128*i +: 128], int'(bus.pixelX),
                                          int'(bus.pixelY), i));
        end else begin
            n_cmp++;
            if (!busy || bus.pixelReady) begin
                n_bad++;
                $display("FAIL busy_state: busy=%0b ready=%0b required 1 0", busy, bus.pixelReady);
            end
            if (bus.outValid) begin
                got.idx   = int'(bus.outLayerIdx);
                got.last  = bus.outLast;
                got.id    = int'(bus.layerID);
                got.er    = bus.readRamEn;
                got.ef    = bus.readFlashEn;
                got.ram   = longint'(bus.ramAddressOffset);
                got.flash = longint'(bus.flashAddress);
                n_cmp++;
                if (got != exp_q[0]) begin
                    n_bad++;
                    $display("FAIL record: got idx=%0d last=%0b id=%0d en=%0b%0b ram=%0d flash=%0d required idx=%0d last=%0b id=%0d en=%0b%0b ram=%0d flash=%0d",
                             got.idx, got.last, got.id, got.er, got.ef, got.ram, got.flash,
                             exp_q[0].idx, exp_q[0].last, exp_q[0].id, exp_q[0].er,
                             exp_q[0].ef, exp_q[0].ram, exp_q[0].flash);
                end
                if (bus.outReady) begin
                    void'(exp_q.pop_front());
                    got_q.push_back(got);
                end
            end
        end
    end

    task automatic chk(string name, longint act, longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pixel(int x, int y);
        int t;
        t = 0;
        while (!bus.pixelReady && t < 300) begin
            step();
            t++;
        end
        bus.pixelX = PW'(x);
        bus.pixelY = PW'(y);
        bus.pixelValid = 1'b1;
        step();
        bus.pixelValid = 1'b0;
    endtask

    task automatic wait_idle(bit rnd);
        int t;
        t = 0;
        while (!bus.pixelReady && t < 300) begin
            if (rnd) bus.outReady = ($urandom_range(9) < 7);
            step();
            t++;
        end
        bus.outReady = 1'b1;
        chk("scan_done", longint'(bus.pixelReady), 1);
    endtask

    task automatic run(int x, int y);
        got_q.delete();
        send_pixel(x, y);
        wait_idle(1'b0);
        chk("rec_count", got_q.size(), NL);
    endtask

    function automatic logic [127:0] rand_hdr();
        int w, g;
        w = ($urandom_range(9) == 0) ? int'($urandom_range(65535)) : int'($urandom_range(40, 1));
        g = ($urandom_range(9) == 0) ? 15 : int'($urandom_range(5));
        return mk_hdr($urandom_range(3) != 0, $urandom_range(1) == 1,
                      int'($urandom_range(255)), w, int'($urandom_range(40, 1)),
                      int'($urandom_range(220)) - 20, int'($urandom_range(220)) - 20,
                      int'($urandom_range(65535)), g, int'($urandom_range(255)));
    endfunction

    logic [127:0] spr_h;
    logic [127:0] txt_h;

    initial begin
        bus.pixelValid = 1'b0;
        bus.pixelX = '0;
        bus.pixelY = '0;
        bus.outReady = 1'b1;
        headers = '0;
        spr_h = mk_hdr(1, 1, 7, 16, 8, 100, 50, 0, 0, 2);
        txt_h = mk_hdr(1, 0, 9, 5, 8, 0, 0, 1, 3, 0);
        repeat (3) @(posedge clk);
        #1 resetN = 1'b1;
        step();

        // sprite hit with exact latency; layer 1 unpopulated
        headers = {128'd0, spr_h};
        got_q.delete();
        send_pixel(103, 52);
        chk("lat_empty", longint'(bus.outValid), 0);
        step();
        chk("lat_valid0", longint'(bus.outValid), 1);
        chk("lat_idx0", longint'(bus.outLayerIdx), 0);
        chk("lat_last0", longint'(bus.outLast), 0);
        step();
        chk("lat_idx1", longint'(bus.outLayerIdx), 1);
        chk("lat_last1", longint'(bus.outLast), 1);
        step();
        chk("ready_back", longint'(bus.pixelReady), 1);
        chk("t1_count", got_q.size(), 2);
        chk("spr_ram", got_q[0].ram, 291);
        chk("spr_ramen", longint'(got_q[0].er), 1);
        chk("spr_flashen", longint'(got_q[0].ef), 0);
        chk("spr_id", got_q[0].id, 7);
        chk("unpop_en", longint'(got_q[1].er) + longint'(got_q[1].ef), 0);
        chk("unpop_ram", got_q[1].ram, 0);

        // text glyph
        headers = {128'd0, txt_h};
        run(19, 6);
        chk("txt_ram", got_q[0].ram, 2);
        chk("txt_flash", got_q[0].flash, 4147);
        chk("txt_en", longint'(got_q[0].er) + longint'(got_q[0].ef), 2);

        // sprite right/left edges
        headers = {128'd0, spr_h};
        run(115, 52);
        chk("edge_hit_ram", got_q[0].ram, 303);
        chk("edge_hit_en", longint'(got_q[0].er), 1);
        run(116, 52);
        chk("edge_miss_en", longint'(got_q[0].er), 0);
        chk("edge_miss_ram", got_q[0].ram, 0);
        run(99, 52);
        chk("neg_miss_en", longint'(got_q[0].er), 0);
        chk("neg_miss_ram", got_q[0].ram, 0);

        // backpressure on first record
        got_q.delete();
        bus.outReady = 1'b0;
        send_pixel(103, 52);
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", longint'(bus.outValid), 1);
            chk("bp_idx", longint'(bus.outLayerIdx), 0);
            chk("bp_ram", longint'(bus.ramAddressOffset), 291);
            chk("bp_busy", longint'(busy), 1);
            step();
        end
        bus.outReady = 1'b1;
        step();
        chk("bp_next_idx", longint'(bus.outLayerIdx), 1);
        step();
        chk("bp_done", longint'(bus.pixelReady), 1);
        chk("bp_count", got_q.size(), 2);

        // reset mid-scan
        got_q.delete();
        send_pixel(103, 52);
        step();
        step();
        resetN = 1'b0;
        #1;
        chk("rst_valid", longint'(bus.outValid), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_ready", longint'(bus.pixelReady), 1);
        step();
        step();
        resetN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_quiet", longint'(bus.outValid), 0);
        end
        run(103, 52);
        chk("post_rst_idx0", got_q[0].idx, 0);
        chk("post_rst_idx1", got_q[1].idx, 1);

        // random headers, pixels, backpressure
        for (int it = 0; it < 250; it++) begin
            for (int l = 0; l < NL; l++) headers[128*l +: 128] = rand_hdr();
            repeat ($urandom_range(2)) step();
            if ($urandom_range(7) == 0)
                send_pixel(int'($urandom_range(2047)), int'($urandom_range(2047)));
            else
                send_pixel(int'($urandom_range(255)), int'($urandom_range(255)));
            wait_idle(1'b1);
        end
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end
endmodule
